// File: rtl/data_supplier.sv
// data_supplier: assembles little-endian bytes into words, buffers them in a FIFO and hands them out on request.
// Optional feature macro: DATA_SUPPLIER_CHECKSUM_EN (per-word XOR checksum byte, bad words dropped and counted).
module data_supplier #(
    parameter int BYTES_PER_WORD = 4,
    parameter int DEPTH = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    output logic                          byte_ready,
    input  logic                          out_of_data,
    output logic                          load_en,
    output logic [8*BYTES_PER_WORD-1:0]   data_out,
    output logic [$clog2(DEPTH):0]        word_count
`ifdef DATA_SUPPLIER_CHECKSUM_EN
    ,
    output logic [7:0]                    err_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int W = 8 * BYTES_PER_WORD;
    localparam int IW = $clog2(BYTES_PER_WORD + 1);
`ifdef DATA_SUPPLIER_CHECKSUM_EN
    localparam int LAST = BYTES_PER_WORD;
`else
    localparam int LAST = BYTES_PER_WORD - 1;
`endif
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_REL} state_t;
    state_t state;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] asm_word, word_next;
    logic [IW-1:0] idx;
    logic [AW-1:0] wptr, rptr;
    logic last, accept, push, pop, load_r;
    assign last = idx == IW'(LAST);
    // word_count never exceeds DEPTH = 2**AW, so its MSB alone means full
    assign byte_ready = !word_count[AW] || !last;
    assign accept = byte_valid && byte_ready;
    assign pop = state == LOAD;
    assign load_en = load_r && !reset;
    // merge the incoming byte into its lane of the partially assembled word
    always_comb begin
        word_next = asm_word;
        for (int k = 0; k < BYTES_PER_WORD; k++)
            if (idx == IW'(k)) word_next[8*k +: 8] = byte_in;
    end
`ifdef DATA_SUPPLIER_CHECKSUM_EN
    logic [7:0] chk;
    // running XOR of the assembled data bytes, compared against the trailing checksum byte
    always_comb begin
        chk = 8'h00;
        for (int k = 0; k < BYTES_PER_WORD; k++) chk = chk ^ asm_word[8*k +: 8];
    end
    assign push = accept && last && byte_in == chk;
    // count dropped words, saturating
    always_ff @(posedge clock) begin
        if (reset) err_count <= 8'h00;
        else if (accept && last && byte_in != chk && err_count != 8'hff) err_count <= err_count + 8'h01;
    end
`else
    assign push = accept && last;
`endif
    // byte lane index and assembly register
    always_ff @(posedge clock) begin
        if (reset) begin
            idx <= '0;
            asm_word <= '0;
        end else if (accept) begin
            idx <= last ? '0 : idx + IW'(1);
            asm_word <= word_next;
        end
    end
    // buffer storage, written at the tail on a completed word
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= word_next;
    end
    // FIFO pointers and occupancy; push and pop in one cycle cancel out
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            word_count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            word_count <= word_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // output handshake FSM: one load per out_of_data request, re-armed when the request drops
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            load_r <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: if (out_of_data && word_count != '0) begin
                    state <= LOAD;
                    load_r <= 1'b1;
                    data_out <= mem[rptr];
                end
                LOAD: begin
                    state <= WAIT_REL;
                    load_r <= 1'b0;
                end
                WAIT_REL: if (!out_of_data) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_supplier.sv
// tb_data_supplier: scoreboard bench for data_supplier with default parameters.
module tb_data_supplier;
    logic clock = 0, reset = 1, byte_valid = 0, out_of_data = 0;
    logic [7:0] byte_in = 0;
    logic byte_ready, load_en;
    logic [31:0] data_out;
    logic [1:0] word_count;
`ifdef DATA_SUPPLIER_CHECKSUM_EN
    logic [7:0] err_count;
`endif
    int checks = 0, errors = 0;
    logic [31:0] exp_q[$], obs_q[$];
    logic [31:0] got, want;

    data_supplier dut (
        .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .out_of_data(out_of_data), .load_en(load_en),
        .data_out(data_out), .word_count(word_count)
`ifdef DATA_SUPPLIER_CHECKSUM_EN
        , .err_count(err_count)
`endif
    );

    always #5 clock = ~clock;

    // every load strobe is captured for the scoreboard
    always @(negedge clock) if (load_en) obs_q.push_back(data_out);

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task tick;
        @(posedge clock);
        #1;
    endtask

    task send_byte(input logic [7:0] b);
        logic ok;
        ok = 0;
        byte_in = b;
        byte_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            ok = byte_ready;
            tick();
        end
        byte_valid = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL send_byte timeout byte=%h ready=0 required=1", b); end
    endtask

    task send_word(input logic [31:0] w);
        exp_q.push_back(w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
`ifdef DATA_SUPPLIER_CHECKSUM_EN
        send_byte(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
    endtask

    task check_one_load(input string name);
        checks++;
        if (obs_q.size() != 1) begin errors++; $display("FAIL %s loads got=%0d exp=1", name, obs_q.size()); end
        got = obs_q.size() > 0 ? obs_q.pop_front() : 32'hx;
        want = exp_q.size() > 0 ? exp_q.pop_front() : 32'hx;
        checks++;
        if (got !== want) begin errors++; $display("FAIL %s data got=%h exp=%h", name, got, want); end
        obs_q.delete();
    endtask

    task test_reset;
        reset = 1;
        tick(); tick();
        reset = 0;
        exp_q.delete(); obs_q.delete();
        @(negedge clock);
        checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL reset_load_en got=%b exp=0", load_en); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        checks++; if (word_count !== 2'd0) begin errors++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_byte_ready got=%b exp=1", byte_ready); end
        tick();
    endtask

    task test_basic_load;
        out_of_data = 1;
        send_word(32'h44332211);
        @(negedge clock);
        checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL latency_early got=%b exp=0", load_en); end
        @(negedge clock);
        checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL latency_load got=%b exp=1", load_en); end
        tick(); tick();
        out_of_data = 0;
        @(negedge clock);
        checks++; if (word_count !== 2'd0) begin errors++; $display("FAIL basic_count got=%0d exp=0", word_count); end
        tick();
        check_one_load("basic");
    endtask

    task test_full;
        logic ok;
        send_word(32'hA4A3A2A1);
        send_word(32'hB4B3B2B1);
        exp_q.push_back(32'hC4C3C2C1);
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        byte_in = 8'hC4;
        byte_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL full_ready cycle=%0d got=%b exp=0", i, byte_ready); end
        end
        checks++; if (word_count !== 2'd2) begin errors++; $display("FAIL full_count got=%0d exp=2", word_count); end
        tick();
        out_of_data = 1;
        tick();
        out_of_data = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            ok = byte_ready;
            tick();
        end
        byte_valid = 0;
        checks++; if (!ok) begin errors++; $display("FAIL pending_accept ready=0 exp=1"); end
        repeat (3) tick();
        @(negedge clock);
        checks++; if (word_count !== 2'd2) begin errors++; $display("FAIL refill_count got=%0d exp=2", word_count); end
        tick();
        check_one_load("pulse");
    endtask

    task test_hold;
        out_of_data = 1;
        repeat (10) tick();
        check_one_load("hold");
        out_of_data = 0;
        tick(); tick();
        out_of_data = 1;
        repeat (4) tick();
        out_of_data = 0;
        check_one_load("hold_second");
        @(negedge clock);
        checks++; if (word_count !== 2'd0) begin errors++; $display("FAIL hold_count got=%0d exp=0", word_count); end
        tick();
    endtask

    task test_empty_wait;
        out_of_data = 1;
        repeat (5) tick();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL empty_no_load got=%0d exp=0", obs_q.size()); end
        send_word(32'h0D0C0B0A);
        repeat (4) tick();
        out_of_data = 0;
        tick();
        check_one_load("empty_wait");
    endtask

    task test_reset_midword;
        send_byte(8'h01); send_byte(8'h02);
        reset = 1;
        tick();
        reset = 0;
        out_of_data = 1;
        send_word(32'hDDCCBBAA);
        repeat (4) tick();
        out_of_data = 0;
        tick();
        check_one_load("midword");
        out_of_data = 1;
        send_word(32'h55667788);
        tick();
        reset = 1;
        @(negedge clock);
        checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL reset_in_load got=%b exp=0", load_en); end
        tick();
        reset = 0;
        out_of_data = 0;
        exp_q.delete();
        @(negedge clock);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_in_load_loads got=%0d exp=0", obs_q.size()); end
        checks++; if (data_out !== 32'h0 || word_count !== 2'd0) begin errors++; $display("FAIL reset_in_load_state data=%h count=%0d exp=0,0", data_out, word_count); end
        tick();
    endtask

`ifdef DATA_SUPPLIER_CHECKSUM_EN
    task test_checksum;
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL err_reset got=%0d exp=0", err_count); end
        out_of_data = 1;
        send_word(32'h04030201);
        repeat (4) tick();
        out_of_data = 0;
        tick();
        check_one_load("chk_good");
        out_of_data = 1;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        repeat (4) tick();
        out_of_data = 0;
        @(negedge clock);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL chk_bad_loads got=%0d exp=0", obs_q.size()); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL chk_err_count got=%0d exp=1", err_count); end
        checks++; if (word_count !== 2'd0) begin errors++; $display("FAIL chk_count got=%0d exp=0", word_count); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_full();
        test_hold();
        test_empty_wait();
        test_reset_midword();
`ifdef DATA_SUPPLIER_CHECKSUM_EN
        test_reset();
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_supplier.md
DATA_SUPPLIER -- requirements
Module: data_supplier

Interface
REQ-001 Parameter BYTES_PER_WORD, default 4, number of bytes assembled little-endian into one data word (2..8).
REQ-002 Parameter DEPTH, default 2, number of complete words the output buffer holds (power of 2, >= 2).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 byte_in  input  8  incoming data byte.
REQ-006 byte_valid  input  1  byte_in is valid this cycle.
REQ-007 byte_ready  output  1  block accepts byte_in this cycle; a byte transfers when byte_valid && byte_ready.
REQ-008 out_of_data  input  1  consumer requests a new word (level).
REQ-009 load_en  output  1  one-cycle strobe; consumer registers data_out on this cycle.
REQ-010 data_out  output  8*BYTES_PER_WORD  word presented with load_en.
REQ-011 word_count  output  $clog2(DEPTH)+1  complete words currently buffered.
REQ-012 err_count  output  8  dropped-word counter (present only with DATA_SUPPLIER_CHECKSUM_EN).

Function
REQ-013 Assembler SHALL place the k-th accepted byte of a word at data bits [8k+7:8k], k = 0 first.
REQ-014 On acceptance of the final byte, the word SHALL be written to the buffer on that edge; word_count reflects it the next cycle.
REQ-015 byte_ready SHALL be 1 when word_count < DEPTH or the current byte is not the final byte of a word, else 0.
REQ-016 Buffer SHALL be FIFO-ordered; pointers wrap modulo DEPTH.
REQ-017 Simultaneous push and pop in one cycle SHALL leave word_count unchanged and lose no word, including when full.
REQ-018 Output FSM states: IDLE, LOAD, WAIT_REL.
REQ-019 IDLE -> LOAD when out_of_data == 1 and word_count > 0; otherwise stay in IDLE.
REQ-020 LOAD SHALL assert load_en for exactly one cycle with data_out = FIFO head, pop the head, then go to WAIT_REL.
REQ-021 WAIT_REL -> IDLE when out_of_data == 0; load_en SHALL stay 0 while in WAIT_REL.
REQ-022 Latency: out_of_data sampled high at edge N with a word buffered -> load_en high in cycle N+1.
REQ-023 If out_of_data is high and buffer is empty, FSM SHALL wait in IDLE and move to LOAD on the cycle after the first word completes.
REQ-024 data_out SHALL hold its last loaded value outside LOAD.

Reset
REQ-025 reset SHALL clear FSM to IDLE, pointers, word_count and byte index to 0, and data_out, load_en and err_count to 0.
REQ-026 byte_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-027 reset mid-word SHALL discard the partial word; reset during LOAD SHALL suppress load_en that cycle.

Configuration
REQ-028 Macro DATA_SUPPLIER_CHECKSUM_EN SHALL, when defined, append one checksum byte per word: XOR of the BYTES_PER_WORD data bytes.
REQ-029 With the macro, a word SHALL be pushed only if the checksum matches; on mismatch it SHALL be dropped and err_count incremented, saturating at 255.
REQ-030 With the macro, byte_ready gating of REQ-015 SHALL apply to the checksum byte instead of the final data byte.
REQ-031 Without the macro, no checksum byte is expected, err_count is absent, and a word is pushed on its final data byte.

Verification
REQ-032 Reset, then bytes 0x11,0x22,0x33,0x44 with out_of_data=1 -> load_en one cycle, data_out=0x44332211, word_count returns to 0.
REQ-033 Push 3 words with out_of_data=0 -> byte_ready drops on the 3rd word's final byte and stays 0; word_count=2.
REQ-034 Full buffer, out_of_data pulsed high then low -> exactly one load_en, word 1 out, pending byte then accepted.
REQ-035 out_of_data held high for 10 cycles with 2 words buffered -> exactly one load_en until out_of_data falls.
REQ-036 Reset asserted after 2 bytes of a word, then 0xAA,0xBB,0xCC,0xDD -> data_out=0xDDCCBBAA.
REQ-037 With DATA_SUPPLIER_CHECKSUM_EN: bytes 01,02,03,04 then 0x04 -> word loaded; then 01,02,03,04 with 0x05 -> dropped, err_count=1, no load_en.
